diff_rx: RTL and testbench

- Receive-side decoder for the single-wire pulse-width-coded link driven by diff_tx.
- Samples the line, measures the low time of each symbol and classifies it as SYNC, ZERO or ONE.
- Assembles a 26-bit frame (leading SYNC, 26 bits MSB first, trailing SYNC) and presents it with a one-cycle valid strobe.
- Flags malformed frames with an error strobe.

---
 rtl/diff_rx.sv | 180 ++++++++++++++++++
 tb/tb_diff_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/diff_rx.sv
// Pulse-width-coded line receiver: classifies each low run as SYNC/ZERO/ONE
// and assembles 26-bit frames framed by a leading and a trailing SYNC.
//   state | meaning
//   IDLE  | waiting for a leading SYNC
//   DATA  | shifting in the 26 data bits
//   TAIL  | all bits received, waiting for the trailing SYNC
module diff_rx #(
  parameter int DATA_PERIOD  = 20,
  parameter int ZERO_MAX_LOW = 7,
  parameter int ONE_MIN_LOW  = 13,
  parameter int LOW_MAX      = 19,
  parameter int HIGH_TIMEOUT = 40
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        data_in,
  output logic [25:0] data_out,
  output logic        valid_out,
  output logic        error_out,
  output logic [1:0]  state_out
);

  localparam int LOW_SPAN = (DATA_PERIOD > LOW_MAX + 1) ? DATA_PERIOD : LOW_MAX + 1;
  localparam int LW = $clog2(LOW_SPAN + 1);
  localparam int HW = $clog2(HIGH_TIMEOUT + 1);

  localparam logic [LW-1:0] ZERO_MAX_C = LW'(ZERO_MAX_LOW);
  localparam logic [LW-1:0] ONE_MIN_C  = LW'(ONE_MIN_LOW);
  localparam logic [LW-1:0] LOW_MAX_C  = LW'(LOW_MAX);
  localparam logic [LW-1:0] LOW_SAT_C  = LW'(LOW_MAX + 1);
  localparam logic [HW-1:0] HIGH_SAT_C = HW'(HIGH_TIMEOUT);
  localparam logic [HW-1:0] HIGH_PRE_C = HW'(HIGH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SYM_NONE,
    SYM_ZERO,
    SYM_ONE,
    SYM_SYNC,
    SYM_BAD
  } sym_t;

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          line;
  logic          rise;
  logic [LW-1:0] low_cnt;
  logic [HW-1:0] high_cnt;
  sym_t          sym;
  logic          abort;

  state_t        state, state_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [25:0]   shift_q, shift_n;
  logic [25:0]   data_n;
  logic          valid_n, error_n;

  // Flops preset to 1 so a line idling high produces no edge out of reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], data_in};
      prev_q <= sync_q[1];
    end
  end

  assign line = sync_q[1];
  assign rise = line & ~prev_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      if (rise)
        low_cnt <= '0;
      else if (!line && low_cnt != LOW_SAT_C)
        low_cnt <= low_cnt + 1'b1;

      if (!line)
        high_cnt <= '0;
      else if (high_cnt != HIGH_SAT_C)
        high_cnt <= high_cnt + 1'b1;
    end
  end

  always_comb begin
    sym = SYM_NONE;
    if (rise) begin
      if (low_cnt == '0)
        sym = SYM_BAD;
      else if (low_cnt <= ZERO_MAX_C)
        sym = SYM_ZERO;
      else if (low_cnt < ONE_MIN_C)
        sym = SYM_SYNC;
      else if (low_cnt <= LOW_MAX_C)
        sym = SYM_ONE;
      else
        sym = SYM_BAD;
    end
  end

  // Fires on the edge where a counter reaches its limit, so the error
  // strobe coincides with the counter hitting LOW_MAX+1 / HIGH_TIMEOUT.
  assign abort = (!line && low_cnt == LOW_MAX_C) || (line && high_cnt == HIGH_PRE_C);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_q   <= shift_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      error_out <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    data_n    = data_out;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    case (state)
      IDLE: begin
        if (sym == SYM_SYNC) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (abort) begin
          state_n = IDLE;
          error_n = 1'b1;
        end else if (sym == SYM_ZERO || sym == SYM_ONE) begin
          shift_n   = {shift_q[24:0], (sym == SYM_ONE)};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd25)
            state_n = TAIL;
        end else if (sym == SYM_SYNC) begin
          // Unexpected SYNC restarts the frame as a fresh leading sync.
          error_n   = 1'b1;
          bit_cnt_n = '0;
        end
      end
      TAIL: begin
        if (abort) begin
          state_n = IDLE;
          error_n = 1'b1;
        end else if (sym == SYM_SYNC) begin
          data_n  = shift_q;
          valid_n = 1'b1;
          state_n = IDLE;
        end else if (sym != SYM_NONE) begin
          error_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_diff_rx.sv
// Directed bench for diff_rx: drives symbol waveforms, scoreboards expected
// frames against valid_out, and counts error_out pulses against expectations.
module tb_diff_rx;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        data_in;
  logic [25:0] data_out;
  logic        valid_out;
  logic        error_out;
  logic [1:0]  state_out;

  int checks   = 0;
  int errors   = 0;
  int val_seen = 0;
  int err_seen = 0;
  int cyc      = 0;
  int err_cyc  = 0;
  logic [25:0] exp_q[$];

  diff_rx dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .error_out (error_out),
    .state_out (state_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops the expected frame on every valid strobe.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out || error_out)
        check("pulse_exclusive", 32'(valid_out & error_out), 32'd0);
      if (error_out) begin
        err_seen++;
        err_cyc = cyc;
      end
      if (valid_out) begin
        val_seen++;
        check("valid_with_expectation", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() != 0) begin
          logic [25:0] e;
          e = exp_q.pop_front();
          check("frame_data", 32'(data_out), 32'(e));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic sym(input int lo, input int hi);
    data_in = 1'b0;
    tick(lo);
    data_in = 1'b1;
    tick(hi);
  endtask

  task automatic send_bit(input logic b, input bit tol, input int i);
    int lo;
    if (!tol) lo = b ? 15 : 5;
    else      lo = b ? (i[0] ? 19 : 13) : (i[0] ? 7 : 1);
    sym(lo, 20 - lo);
  endtask

  task automatic send_frame(input logic [25:0] d, input bit tol, input int gap);
    exp_q.push_back(d);
    sym(10, 10);
    for (int i = 25; i >= 0; i--) send_bit(d[i], tol, i);
    sym(10, gap);
  endtask

  initial begin
    int t0;
    int e0;
    int v0;
    logic [25:0] junk;

    rst_in  = 1'b1;
    data_in = 1'b1;
    tick(5);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_error", 32'(error_out), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    rst_in = 1'b0;
    tick(100);
    check("idle_no_valid", 32'(val_seen), 32'd0);
    check("idle_no_error", 32'(err_seen), 32'd0);
    check("idle_state", 32'(state_out), 32'd0);
    check("idle_data", 32'(data_out), 32'd0);

    // Single nominal frame
    send_frame(26'h2C0FFEE, 1'b0, 10);
    tick(10);
    check("single_valid_cnt", 32'(val_seen), 32'd1);
    check("single_err_cnt", 32'(err_seen), 32'd0);
    check("single_state", 32'(state_out), 32'd0);
    check("single_data_hold", 32'(data_out), 32'h2C0FFEE);

    // Back-to-back with a single idle cycle
    send_frame(26'h0000001, 1'b0, 1);
    send_frame(26'h3FFFFFF, 1'b0, 10);
    tick(10);
    check("b2b_valid_cnt", 32'(val_seen), 32'd3);
    check("b2b_err_cnt", 32'(err_seen), 32'd0);
    check("b2b_data", 32'(data_out), 32'h3FFFFFF);

    // Truncated frame: high timeout
    sym(10, 10);
    for (int i = 0; i < 9; i++) send_bit(i[0], 1'b0, i);
    data_in = 1'b0;
    tick(5);
    data_in = 1'b1;
    t0 = cyc;
    tick(5);
    check("trunc_state_data", 32'(state_out), 32'd1);
    tick(55);
    check("trunc_err_cnt", 32'(err_seen), 32'd1);
    check("trunc_err_time", 32'(err_cyc - t0), 32'd42);
    check("trunc_state", 32'(state_out), 32'd0);
    check("trunc_no_valid", 32'(val_seen), 32'd3);
    check("trunc_data_kept", 32'(data_out), 32'h3FFFFFF);

    // Long low mid-frame
    sym(10, 10);
    for (int i = 0; i < 5; i++) send_bit(~i[0], 1'b0, i);
    data_in = 1'b0;
    t0 = cyc;
    tick(30);
    data_in = 1'b1;
    tick(30);
    check("longlow_err_cnt", 32'(err_seen), 32'd2);
    check("longlow_err_time", 32'(err_cyc - t0), 32'd22);
    check("longlow_state", 32'(state_out), 32'd0);

    send_frame(26'h1555555, 1'b0, 10);
    tick(10);
    check("recover_valid_cnt", 32'(val_seen), 32'd4);
    check("recover_err_cnt", 32'(err_seen), 32'd2);

    // Boundary low times 1/7 and 13/19
    send_frame(26'h2A5C3F1, 1'b1, 10);
    tick(10);
    check("tol_valid_cnt", 32'(val_seen), 32'd5);
    check("tol_err_cnt", 32'(err_seen), 32'd2);

    // SYNC injected after 12 bits restarts the frame
    junk = 26'h3A5F0C3;
    sym(10, 10);
    for (int i = 25; i > 13; i--) send_bit(junk[i], 1'b0, i);
    e0 = err_seen;
    send_frame(26'h12345AB, 1'b0, 10);
    tick(10);
    check("midsync_err_cnt", 32'(err_seen - e0), 32'd1);
    check("midsync_valid_cnt", 32'(val_seen), 32'd6);
    check("midsync_data", 32'(data_out), 32'h12345AB);

    // Asynchronous reset in the middle of a frame
    e0 = err_seen;
    v0 = val_seen;
    sym(10, 10);
    for (int i = 0; i < 8; i++) send_bit(i[1], 1'b0, i);
    check("arst_pre_state", 32'(state_out), 32'd1);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("arst_state", 32'(state_out), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_error", 32'(error_out), 32'd0);
    tick(3);
    rst_in = 1'b0;
    tick(100);
    check("arst_no_error", 32'(err_seen - e0), 32'd0);
    check("arst_no_valid", 32'(val_seen - v0), 32'd0);

    send_frame(26'h0ABCDEF, 1'b0, 10);
    tick(10);
    check("final_valid_cnt", 32'(val_seen - v0), 32'd1);
    check("final_data", 32'(data_out), 32'h0ABCDEF);
    check("final_err_cnt", 32'(err_seen - e0), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
